// File: rtl/hdr_pkg.sv
// Shared widths, state encoding and the input-triple struct for the HDR merge stage.
// Every width is derived from the pixel width N and the weight width WW.
package hdr_pkg;
    localparam int N         = 6;
    localparam int WW        = 8;
    localparam int PROD_W    = N + WW;
    localparam int NUM_W     = PROD_W + 2;
    localparam int DEN_W     = WW + 2;
    localparam int DIV_STEPS = N;
    localparam int K_W       = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {IDLE, MAC, DIV, DONE} state_t;

    typedef struct packed {
        logic [N-1:0]  p_high;
        logic [N-1:0]  p_mid;
        logic [N-1:0]  p_low;
        logic [WW-1:0] w_high;
        logic [WW-1:0] w_mid;
        logic [WW-1:0] w_low;
    } triple_t;

    function automatic logic [PROD_W-1:0] mul_pw(input logic [N-1:0] p, input logic [WW-1:0] w);
        return PROD_W'(p) * PROD_W'(w);
    endfunction
endpackage

// File: rtl/div_restoring_serial.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// quotient shows the finished value combinationally in the cycle where done is high.
module div_restoring_serial
    import hdr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [N-1:0]     quotient,
    output logic             done
);
    localparam int SH_W = NUM_W + N;

    logic [NUM_W-1:0] rem, rem_nx;
    logic [DEN_W-1:0] den_r;
    logic [K_W-1:0]   k;
    logic [N-1:0]     q, q_nx;
    logic             busy;
    logic [SH_W-1:0]  dsh;
    logic             ge;

    // Compare in a widened domain so den<<k never truncates.
    always_comb begin
        dsh    = SH_W'(den_r) << k;
        ge     = SH_W'(rem) >= dsh;
        rem_nx = ge ? (rem - dsh[NUM_W-1:0]) : rem;
        q_nx   = q;
        q_nx[k] = ge;
    end

    assign quotient = q_nx;
    assign done     = busy && (k == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem   <= '0;
            den_r <= '0;
            k     <= '0;
            q     <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            rem   <= num;
            den_r <= den;
            k     <= K_W'(DIV_STEPS - 1);
            q     <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            rem <= rem_nx;
            q   <= q_nx;
            if (k == '0) busy <= 1'b0;
            else         k    <= k - 1'b1;
        end
    end
endmodule

// File: rtl/hdr_merge_six.sv
// Fuses three exposure pixels into round(sum(w*p)/sum(w)) behind a valid/ready handshake.
// All-zero weights fall back to the mid exposure and raise zero_w.
module hdr_merge_six
    import hdr_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          in_ready,
    input  logic [N-1:0]  pixel_high,
    input  logic [N-1:0]  pixel_mid,
    input  logic [N-1:0]  pixel_low,
    input  logic [WW-1:0] w_high,
    input  logic [WW-1:0] w_mid,
    input  logic [WW-1:0] w_low,
    output logic [N-1:0]  pixel_out,
    output logic          out_valid,
    output logic          zero_w
);
    state_t           state, state_nx;
    triple_t          trip;
    logic             zero_flag;
    logic             accept;
    logic [DEN_W-1:0] den_c;
    logic [NUM_W-1:0] num_c;
    logic [N-1:0]     div_q;
    logic             div_done;

    assign in_ready = (state == IDLE) || (state == DONE);
    assign accept   = start && in_ready;

    // Half-denominator bias gives round-half-up on the integer quotient.
    always_comb begin
        den_c = DEN_W'(trip.w_high) + DEN_W'(trip.w_mid) + DEN_W'(trip.w_low);
        num_c = NUM_W'(mul_pw(trip.p_high, trip.w_high))
              + NUM_W'(mul_pw(trip.p_mid,  trip.w_mid))
              + NUM_W'(mul_pw(trip.p_low,  trip.w_low))
              + NUM_W'(den_c >> 1);
    end

    div_restoring_serial u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == MAC),
        .num      (num_c),
        .den      (den_c),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MAC;
            MAC:     state_nx = DIV;
            DIV:     if (div_done) state_nx = DONE;
            DONE:    state_nx = start ? MAC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trip      <= '0;
            zero_flag <= 1'b0;
            pixel_out <= '0;
            out_valid <= 1'b0;
            zero_w    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept)
                trip <= '{p_high: pixel_high, p_mid: pixel_mid, p_low: pixel_low,
                          w_high: w_high, w_mid: w_mid, w_low: w_low};
            if (state == MAC)
                zero_flag <= (den_c == '0);
            // The divider still runs for zero weights so latency stays constant.
            if (state == DIV && div_done) begin
                pixel_out <= zero_flag ? trip.p_mid : div_q;
                zero_w    <= zero_flag;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hdr_merge_six.sv
// Scoreboard bench for hdr_merge_six: expectations queued at accept, checked on out_valid.
module tb_hdr_merge_six;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic       in_ready;
    logic [5:0] pixel_high = 0, pixel_mid = 0, pixel_low = 0;
    logic [7:0] w_high = 0, w_mid = 0, w_low = 0;
    logic [5:0] pixel_out;
    logic       out_valid;
    logic       zero_w;

    typedef struct {int pix; int zw; int acc;} exp_t;
    exp_t sb[$];
    int   ov_t[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    hdr_merge_six dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
        .pixel_high(pixel_high), .pixel_mid(pixel_mid), .pixel_low(pixel_low),
        .w_high(w_high), .w_mid(w_mid), .w_low(w_low),
        .pixel_out(pixel_out), .out_valid(out_valid), .zero_w(zero_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pix(input int ph, pm, pl, wh, wm, wl);
        int den, num;
        den = wh + wm + wl;
        if (den == 0) return pm;
        num = ph * wh + pm * wm + pl * wl + den / 2;
        return num / den;
    endfunction

    // Monitor: out_valid appears 7 edges after the accept edge (E0..E7 = 8 edges).
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            ov_t.push_back(cyc);
            if (sb.size() == 0) chk("stray_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("pixel_out", int'(pixel_out), e.pix);
                chk("zero_w", int'(zero_w), e.zw);
                chk("latency", cyc - e.acc, 7);
                chk("ready_done", int'(in_ready), 1);
            end
        end
    end

    // Call at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input int ph, pm, pl, wh, wm, wl, input bit hold);
        int n;
        exp_t e;
        pixel_high = 6'(ph); pixel_mid = 6'(pm); pixel_low = 6'(pl);
        w_high = 8'(wh); w_mid = 8'(wm); w_low = 8'(wl);
        start = 1;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) chk("ready_timeout", 0, 1);
        e.pix = model_pix(ph, pm, pl, wh, wm, wl);
        e.zw  = (wh + wm + wl == 0) ? 1 : 0;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        chk("ready_mac", int'(in_ready), 0);
        if (!hold) start = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_pix", int'(pixel_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_zw", int'(zero_w), 0);
        rst_n = 1;
        @(negedge clk);

        send(63, 32, 0, 1, 32, 1, 0); drain();
        send(1, 2, 2, 1, 1, 1, 0);    drain();
        send(0, 0, 1, 1, 1, 1, 0);    drain();
        send(63, 63, 63, 255, 255, 255, 0); drain();
        send(0, 0, 0, 255, 255, 255, 0);    drain();
        send(10, 20, 30, 0, 0, 0, 0);       drain();
        chk("hold_pix", int'(pixel_out), 20);

        // start held high for three back-to-back triples
        ov_t.delete();
        send(5, 40, 60, 3, 200, 9, 1);
        send(63, 1, 17, 0, 0, 0, 1);
        send(12, 34, 56, 255, 0, 128, 0);
        drain();
        chk("b2b_count", ov_t.size(), 3);
        if (ov_t.size() == 3) begin
            chk("b2b_gap0", ov_t[1] - ov_t[0], 8);
            chk("b2b_gap1", ov_t[2] - ov_t[1], 8);
        end

        // start pulse during MAC/DIV with different data must be ignored
        send(7, 50, 3, 10, 20, 30, 0);
        pixel_high = 63; pixel_mid = 0; pixel_low = 63; w_high = 1; w_mid = 0; w_low = 1;
        start = 1;
        @(negedge clk); @(negedge clk);
        start = 0;
        drain();

        // reset just before the third divide iteration
        send(40, 41, 42, 9, 9, 9, 0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 0;
        start = 1;
        @(negedge clk);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_pix", int'(pixel_out), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_zw", int'(zero_w), 0);
        sb.delete();
        start = 0;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);
        repeat (12) @(negedge clk);
        send(63, 32, 0, 1, 32, 1, 0); drain();

        for (int i = 0; i < 12; i++) begin
            int wh, wm, wl;
            wh = (i % 4 == 0) ? 0 : int'($urandom_range(255));
            wm = (i % 5 == 0) ? 0 : int'($urandom_range(255));
            wl = (i % 3 == 0) ? 0 : int'($urandom_range(255));
            send(int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(63)),
                 wh, wm, wl, (i % 2) == 1);
        end
        start = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
